// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
//
// Multicycle control sequencer for the MIPS core. A Moore state machine walks
// each instruction one state per clock and drives the datapath mux selects
// and write enables. A retired-instruction counter is kept for bring-up.
//
// Ports:
//   clk_i            system clock, rising edge
//   reset_i          synchronous active-high reset
//   op_i6            opcode from the instruction register
//   funct_i6         funct field from the instruction register
//   zero_i           ALU zero flag (only used by BRANCH)
//   iord_o           memory address select (0 PC, 1 ALUOut)
//   mem_write_o      data memory write enable
//   ir_write_o       instruction register load enable
//   pc_en_o          PC load enable
//   reg_write_o      register file write enable
//   reg_dst_o        write register select (0 rt, 1 rd)
//   mem_to_reg_o     writeback select (0 ALUOut, 1 data register)
//   alu_src_a_o      ALU A select (0 PC, 1 register A)
//   alu_src_b_o2     ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   alu_ctrl_o3      ALU operation
//   pc_src_o2        next-PC select (00 ALU, 01 ALUOut, 10 jump)
//   retire_o         high in the final state of a recognised instruction
//   state_o4         current state, debug only
//   instr_count_o32  retired instruction count (wraps)
// ---------------------------------------------------------------------------
module mc_control_fsm (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [5:0]  op_i6,
    input  logic [5:0]  funct_i6,
    input  logic        zero_i,
    output logic        iord_o,
    output logic        mem_write_o,
    output logic        ir_write_o,
    output logic        pc_en_o,
    output logic        reg_write_o,
    output logic        reg_dst_o,
    output logic        mem_to_reg_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o2,
    output logic [2:0]  alu_ctrl_o3,
    output logic [1:0]  pc_src_o2,
    output logic        retire_o,
    output logic [3:0]  state_o4,
    output logic [31:0] instr_count_o32
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Unknown funct codes fall back to add so the datapath stays benign.
    function automatic logic [2:0] alu_from_funct(input logic [5:0] funct);
        logic [2:0] ctrl;
        case (funct)
            6'b100000: ctrl = ALU_ADD;
            6'b100010: ctrl = ALU_SUB;
            6'b100100: ctrl = ALU_AND;
            6'b100101: ctrl = ALU_OR;
            6'b101010: ctrl = ALU_SLT;
            default:   ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

    state_t      r_state;
    state_t      w_next_state;
    state_t      w_dec_state;
    logic [31:0] r_count;

    logic        w_iord;
    logic        w_mem_write;
    logic        w_ir_write;
    logic        w_pc_en;
    logic        w_reg_write;
    logic        w_reg_dst;
    logic        w_mem_to_reg;
    logic        w_alu_src_a;
    logic [1:0]  w_alu_src_b;
    logic [2:0]  w_alu_ctrl;
    logic [1:0]  w_pc_src;
    logic        w_retire;

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Retired-instruction counter, wraps naturally at 32 bits.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count <= 32'd0;
        end else if (w_retire) begin
            r_count <= r_count + 32'd1;
        end else begin
            r_count <= r_count;
        end
    end

    // Next-state logic; illegal codes recover to FETCH.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (op_i6)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXEC;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_J:         w_next_state = S_JUMP;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op_i6 == OP_LW) begin
                    w_next_state = S_MEMRD;
                end else begin
                    w_next_state = S_MEMWR;
                end
            end
            S_MEMRD:  w_next_state = S_MEMWB;
            S_EXEC:   w_next_state = S_ALUWB;
            S_ADDIEX: w_next_state = S_ADDIWB;
            default:  w_next_state = S_FETCH;
        endcase
    end

    // While reset is held the outputs present FETCH, so a state register that
    // has not yet seen an edge never leaks unknown selects to the datapath.
    assign w_dec_state = reset_i ? S_FETCH : r_state;

    // Moore output decode; only BRANCH looks at an input (zero_i).
    always_comb begin
        w_iord       = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_en      = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_alu_ctrl   = ALU_ADD;
        w_pc_src     = 2'b00;
        w_retire     = 1'b0;
        case (w_dec_state)
            S_FETCH: begin
                w_ir_write  = 1'b1;
                w_alu_src_b = 2'b01;
                w_pc_en     = 1'b1;
            end
            S_DECODE: w_alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            S_MEMRD: w_iord = 1'b1;
            S_MEMWB: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
            end
            S_MEMWR: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_ctrl  = alu_from_funct(funct_i6);
            end
            S_ALUWB: begin
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a = 1'b1;
                w_alu_ctrl  = ALU_SUB;
                w_pc_src    = 2'b01;
                w_pc_en     = zero_i;
                w_retire    = 1'b1;
            end
            S_JUMP: begin
                w_pc_src = 2'b10;
                w_pc_en  = 1'b1;
                w_retire = 1'b1;
            end
            default: begin
                w_retire = 1'b0;
            end
        endcase
    end

    // Write enables and retire are suppressed during reset.
    assign iord_o          = w_iord;
    assign mem_write_o     = w_mem_write & ~reset_i;
    assign ir_write_o      = w_ir_write  & ~reset_i;
    assign pc_en_o         = w_pc_en     & ~reset_i;
    assign reg_write_o     = w_reg_write & ~reset_i;
    assign reg_dst_o       = w_reg_dst;
    assign mem_to_reg_o    = w_mem_to_reg;
    assign alu_src_a_o     = w_alu_src_a;
    assign alu_src_b_o2    = w_alu_src_b;
    assign alu_ctrl_o3     = w_alu_ctrl;
    assign pc_src_o2       = w_pc_src;
    assign retire_o        = w_retire    & ~reset_i;
    assign state_o4        = r_state;
    assign instr_count_o32 = r_count;

endmodule

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm
//
// Scoreboard bench. The driver issues whole instructions (directed ones from
// the test plan, then random ones), and for every clock cycle pushes the
// expected state, control vector and retired count into a queue. A separate
// monitor pops one entry per cycle on the falling edge and compares.
// The reference model describes an instruction as its list of phases and
// counts completed instructions; it knows nothing of the RTL internals.
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [5:0]  op_i6;
    logic [5:0]  funct_i6;
    logic        zero_i;
    logic        iord_o;
    logic        mem_write_o;
    logic        ir_write_o;
    logic        pc_en_o;
    logic        reg_write_o;
    logic        reg_dst_o;
    logic        mem_to_reg_o;
    logic        alu_src_a_o;
    logic [1:0]  alu_src_b_o2;
    logic [2:0]  alu_ctrl_o3;
    logic [1:0]  pc_src_o2;
    logic        retire_o;
    logic [3:0]  state_o4;
    logic [31:0] instr_count_o32;

    mc_control_fsm dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .op_i6           (op_i6),
        .funct_i6        (funct_i6),
        .zero_i          (zero_i),
        .iord_o          (iord_o),
        .mem_write_o     (mem_write_o),
        .ir_write_o      (ir_write_o),
        .pc_en_o         (pc_en_o),
        .reg_write_o     (reg_write_o),
        .reg_dst_o       (reg_dst_o),
        .mem_to_reg_o    (mem_to_reg_o),
        .alu_src_a_o     (alu_src_a_o),
        .alu_src_b_o2    (alu_src_b_o2),
        .alu_ctrl_o3     (alu_ctrl_o3),
        .pc_src_o2       (pc_src_o2),
        .retire_o        (retire_o),
        .state_o4        (state_o4),
        .instr_count_o32 (instr_count_o32)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic [31:0] cnt;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_no   = 0;
    logic [31:0] model_count = 32'd0;

    // Number of cycles an instruction spends, counted from FETCH entry.
    function automatic int n_phases(input logic [5:0] op);
        case (op)
            6'b100011: return 5;                 // lw
            6'b101011: return 4;                 // sw
            6'b000000: return 4;                 // R-type
            6'b001000: return 4;                 // addi
            6'b000100: return 3;                 // beq
            6'b000010: return 3;                 // j
            default:   return 2;                 // unrecognised
        endcase
    endfunction

    function automatic logic recognised(input logic [5:0] op);
        return n_phases(op) > 2;
    endfunction

    // Debug state code shown during phase k of an instruction.
    function automatic logic [3:0] phase_at(input logic [5:0] op, input int k);
        if (k == 0) return 4'd0;
        if (k == 1) return 4'd1;
        case (op)
            6'b100011: return (k == 2) ? 4'd2 : ((k == 3) ? 4'd3 : 4'd4);
            6'b101011: return (k == 2) ? 4'd2 : 4'd5;
            6'b000000: return (k == 2) ? 4'd6 : 4'd7;
            6'b001000: return (k == 2) ? 4'd9 : 4'd10;
            6'b000100: return 4'd8;
            6'b000010: return 4'd11;
            default:   return 4'd0;
        endcase
    endfunction

    // Expected control vector, layout:
    // {iord, mem_write, ir_write, pc_en, reg_write, reg_dst, mem_to_reg,
    //  alu_src_a, alu_src_b[1:0], alu_ctrl[2:0], pc_src[1:0], retire}
    function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic [5:0] fn,
                                             input logic z, input logic rst);
        logic       iord = 1'b0, mw = 1'b0, irw = 1'b0, pcen = 1'b0, rw = 1'b0;
        logic       rd = 1'b0, m2r = 1'b0, sa = 1'b0, ret = 1'b0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        logic [2:0] alu = 3'b010;
        if (rst) begin
            sb = 2'b01;
        end else begin
            case (st)
                4'd0:  begin irw = 1'b1; sb = 2'b01; pcen = 1'b1; end
                4'd1:  sb = 2'b11;
                4'd2, 4'd9: begin sa = 1'b1; sb = 2'b10; end
                4'd3:  iord = 1'b1;
                4'd4:  begin m2r = 1'b1; rw = 1'b1; ret = 1'b1; end
                4'd5:  begin iord = 1'b1; mw = 1'b1; ret = 1'b1; end
                4'd6: begin
                    sa = 1'b1;
                    if (fn == 6'b100010)      alu = 3'b110;
                    else if (fn == 6'b100100) alu = 3'b000;
                    else if (fn == 6'b100101) alu = 3'b001;
                    else if (fn == 6'b101010) alu = 3'b111;
                    else                      alu = 3'b010;
                end
                4'd7:  begin rd = 1'b1; rw = 1'b1; ret = 1'b1; end
                4'd8:  begin sa = 1'b1; alu = 3'b110; ps = 2'b01; pcen = z; ret = 1'b1; end
                4'd10: begin rw = 1'b1; ret = 1'b1; end
                4'd11: begin ps = 2'b10; pcen = 1'b1; ret = 1'b1; end
                default: ;
            endcase
        end
        return {iord, mw, irw, pcen, rw, rd, m2r, sa, sb, alu, ps, ret};
    endfunction

    // Drive one cycle's inputs, record what the DUT must show, advance a clock.
    task automatic drive_cycle(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic [3:0] st);
        exp_t e;
        reset_i  = rst;
        op_i6    = op;
        funct_i6 = fn;
        zero_i   = z;
        e.st   = st;
        e.ctrl = exp_ctrl(st, fn, z, rst);
        e.cnt  = model_count;
        e.cyc  = cyc_no;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        cyc_no++;
    endtask

    // One instruction; rst_step >= 0 asserts reset in that phase and abandons it.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int rst_step,
                             input int zsel);
        int n;
        logic z;
        n = n_phases(op);
        for (int k = 0; k < n; k++) begin
            z = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            if (k == rst_step) begin
                drive_cycle(1'b1, op, fn, z, phase_at(op, k));
                model_count = 32'd0;
                return;
            end
            drive_cycle(1'b0, op, fn, z, phase_at(op, k));
        end
        if (recognised(op)) model_count = model_count + 32'd1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req,
                         input int cyc);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, req);
        end
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    always @(negedge clk_i) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state", {28'd0, state_o4}, {28'd0, e.st}, e.cyc);
            check("ctrl", {16'd0, iord_o, mem_write_o, ir_write_o, pc_en_o, reg_write_o,
                           reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o2, alu_ctrl_o3,
                           pc_src_o2, retire_o}, {16'd0, e.ctrl}, e.cyc);
            check("count", instr_count_o32, e.cnt, e.cyc);
        end
    end

    localparam logic [5:0] OPS [6] = '{6'b100011, 6'b101011, 6'b000000,
                                       6'b001000, 6'b000100, 6'b000010};
    localparam logic [5:0] FNS [5] = '{6'b100000, 6'b100010, 6'b100100,
                                       6'b100101, 6'b101010};

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        int         rs;
        reset_i  = 1'b1;
        op_i6    = 6'd0;
        funct_i6 = 6'd0;
        zero_i   = 1'b0;
        @(posedge clk_i);
        #1;
        // Reset held two cycles: FETCH with enables suppressed, count cleared.
        drive_cycle(1'b1, 6'd0, 6'd0, 1'b0, 4'd0);
        drive_cycle(1'b1, 6'd0, 6'd0, 1'b1, 4'd0);
        model_count = 32'd0;

        run_instr(6'b100011, 6'b000000, -1, -1);     // lw
        run_instr(6'b000100, 6'b000000, -1, 1);      // beq taken
        run_instr(6'b000100, 6'b000000, -1, 0);      // beq not taken
        run_instr(6'b000000, 6'b100010, -1, -1);     // sub
        run_instr(6'b000000, 6'b111111, -1, -1);     // unknown funct
        run_instr(6'b111111, 6'b000000, -1, -1);     // unknown opcode
        run_instr(6'b101011, 6'b000000, -1, -1);     // sw
        run_instr(6'b001000, 6'b000000, -1, -1);     // addi
        run_instr(6'b000010, 6'b000000, -1, -1);     // j
        run_instr(6'b100011, 6'b000000, 3, -1);      // lw, reset in MEMRD
        run_instr(6'b100011, 6'b000000, -1, -1);     // lw after reset

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 6) == 6) op = 6'($urandom_range(0, 63));
            else op = OPS[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) fn = 6'($urandom_range(0, 63));
            else fn = FNS[$urandom_range(0, 4)];
            rs = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, n_phases(op) - 1)) : -1;
            run_instr(op, fn, rs, -1);
        end

        repeat (3) @(negedge clk_i);
        check("drain", 32'(exp_q.size()), 32'd0, cyc_no);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multicycle control sequencer for the MIPS core, built to replace the single-cycle control path. The datapath becomes multicycle with shared memory, an instruction register and an ALU output register, and this block drives all of its mux selects and write enables one state per clock. It decodes opcode and funct from the instruction register and walks a Moore state machine per instruction. It also keeps a retired-instruction counter for bring-up and debug.

## Interface
Parameters: none.

- clk_i  in  1  system clock; all state updates on the rising edge
- reset_i  in  1  synchronous, active-high reset
- op_i6  in  6  opcode, instr[31:26] from the instruction register
- funct_i6  in  6  funct field, instr[5:0] from the instruction register
- zero_i  in  1  ALU zero flag
- iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write_o  out  1  data memory write enable
- ir_write_o  out  1  instruction register load enable
- pc_en_o  out  1  PC load enable
- reg_write_o  out  1  register file write enable
- reg_dst_o  out  1  write register select: 0 = rt, 1 = rd
- mem_to_reg_o  out  1  writeback select: 0 = ALUOut, 1 = data register
- alu_src_a_o  out  1  ALU A select: 0 = PC, 1 = register A
- alu_src_b_o2  out  2  ALU B select: 00 = register B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_ctrl_o3  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
- pc_src_o2  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- retire_o  out  1  high during the final state of a recognised instruction
- state_o4  out  4  current state, debug only
- instr_count_o32  out  32  count of retired instructions

## Operation
- State encoding:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
  - EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11
  - Codes 12–15 are illegal and go to FETCH on the next edge.
- FETCH goes to DECODE.
- DECODE branches on op_i6:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → EXEC
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JUMP
  - any other opcode → FETCH, with no writes performed
- MEMADR goes to MEMRD for lw and to MEMWR for sw. Opcode is held stable by the IR.
- MEMRD → MEMWB → FETCH.
- MEMWR → FETCH.
- EXEC → ALUWB → FETCH.
- ADDIEX → ADDIWB → FETCH.
- BRANCH → FETCH.
- JUMP → FETCH.
- Outputs are decoded from state only, except pc_en_o. Every output not listed for a state is 0, except alu_ctrl_o3, which defaults to 010.

| State | Asserted outputs |
|---|---|
| FETCH | ir_write_o=1, alu_src_b_o2=01, pc_en_o=1, pc_src_o2=00 |
| DECODE | alu_src_b_o2=11 (branch target computed into ALUOut) |
| MEMADR, ADDIEX | alu_src_a_o=1, alu_src_b_o2=10 |
| MEMRD | iord_o=1 |
| MEMWB | mem_to_reg_o=1, reg_write_o=1 |
| MEMWR | iord_o=1, mem_write_o=1 |
| EXEC | alu_src_a_o=1, alu_ctrl_o3 from funct_i6 |
| ALUWB | reg_dst_o=1, reg_write_o=1 |
| ADDIWB | reg_write_o=1 |
| BRANCH | alu_src_a_o=1, alu_ctrl_o3=110, pc_src_o2=01, pc_en_o=zero_i |
| JUMP | pc_src_o2=10, pc_en_o=1 |

- funct_i6 decode in EXEC:
  - 100000 → 010 (add)
  - 100010 → 110 (sub)
  - 100100 → 000 (and)
  - 100101 → 001 (or)
  - 101010 → 111 (slt)
  - any other value → 010 (add)
- retire_o is high in MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP.
- instr_count_o32 increments by 1 on each edge where retire_o is high. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset:
  - On any edge with reset_i high, the state becomes FETCH and instr_count_o32 becomes 0.
  - While reset_i is high, mem_write_o, ir_write_o, pc_en_o, reg_write_o and retire_o are forced to 0. All other outputs show their FETCH values.
  - Reset mid-instruction abandons the instruction. The next state is FETCH and no count is added.
- Cycles per instruction, counted from FETCH entry:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3
  - unrecognised opcode 2, and not counted
- Combinational paths:
  - All outputs settle from the state register.
  - In BRANCH only, pc_en_o also depends combinationally on zero_i, with zero_i → pc_en_o in the same cycle.
- op_i6 is sampled only in DECODE and MEMADR. funct_i6 is sampled only in EXEC. Both must be stable from the IR during those states.

## Test plan
- Reset: hold reset_i high for 2 cycles → state_o4=0, instr_count_o32=0, all four write enables and retire_o at 0. After release, the first cycle shows ir_write_o=1 and pc_en_o=1.
- lw (op 100011): state_o4 runs 0,1,2,3,4 and then returns to 0. iord_o=1 only in state 3. reg_write_o=1 with mem_to_reg_o=1 only in state 4. Count becomes 1.
- beq (op 000100):
  - with zero_i=1, state_o4 runs 0,1,8 and pc_en_o=1, pc_src_o2=01 in state 8;
  - repeat with zero_i=0 and pc_en_o stays 0 in state 8;
  - both cases increment the count.
- R-type sub (op 000000, funct 100010): alu_ctrl_o3=110 in EXEC. ALUWB shows reg_dst_o=1 and reg_write_o=1. An unknown funct 111111 gives alu_ctrl_o3=010.
- Unknown opcode 111111: state_o4 runs 0,1,0, with no write enable asserted in DECODE and the count unchanged.
- Reset mid-operation: assert reset_i during MEMRD of a lw → next state_o4=0, no reg_write_o pulse, count cleared to 0.
